// File: rtl/uart_tx_fifo.sv
// UART transmitter with a valid/ready transmit FIFO, run-time frame format and line break.
// state | meaning: IDLE line high or break | START start bit | DATA data bits | PARITY parity bit | STOP stop bit(s)
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_WIDTH-1:0]          baudrate_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          tx_break,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          uart_txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_n;
  logic                 fifo_ne;
  logic                 push, pop;
  logic [DIV_WIDTH-1:0] cnt, cnt_n, cnt_inc, div_s;
  logic [2:0]           bit_idx, bit_n, last_bit;
  logic [7:0]           data_s;
  logic [1:0]           nbits_s, par_s;
  logic                 stop2_s, brk_hold, brk_n, txd_n;
  logic                 par_bit, par_en, bit_end, can_start;

  assign push    = tx_valid & tx_ready;
  assign count_n = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_ready <= 1'b0;
      fifo_ne  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_n;
      tx_ready <= (count_n != CW'(FIFO_DEPTH));
      // Lagged non-empty flag gives the two-edge push-to-start latency.
      fifo_ne  <= (count != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  assign bit_end   = (cnt == div_s);
  assign cnt_inc   = cnt + DIV_WIDTH'(1);
  assign last_bit  = 3'd4 + {1'b0, nbits_s};
  assign par_en    = (par_s == 2'b01) || (par_s == 2'b10);
  assign par_bit   = (^(data_s & (8'hFF >> (2'd3 - nbits_s)))) ^ (par_s == 2'b10);
  assign can_start = fifo_ne && (count != '0) && !tx_break && !brk_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      brk_hold <= 1'b0;
      uart_txd <= 1'b1;
      data_s   <= '0;
      nbits_s  <= '0;
      par_s    <= '0;
      stop2_s  <= 1'b0;
      div_s    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      brk_hold <= brk_n;
      uart_txd <= txd_n;
      if (pop) begin
        data_s  <= mem[rd_ptr];
        nbits_s <= cfg_data_bits;
        par_s   <= cfg_parity;
        stop2_s <= cfg_stop2;
        div_s   <= baudrate_div;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt_inc;
    bit_n   = bit_idx;
    brk_n   = brk_hold;
    txd_n   = uart_txd;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (tx_break) begin
          txd_n = 1'b0;
          brk_n = 1'b1;
          cnt_n = '0;
        end else if (brk_hold) begin
          // Mark-after-break: hold the line high for one live bit period.
          txd_n = 1'b1;
          if (cnt >= baudrate_div) begin
            brk_n = 1'b0;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end else if (can_start) begin
          pop     = 1'b1;
          cnt_n   = '0;
          txd_n   = 1'b0;
          state_n = START;
        end else begin
          txd_n = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
          txd_n   = data_s[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == last_bit) begin
            bit_n = '0;
            if (par_en) begin
              state_n = PARITY;
              txd_n   = par_bit;
            end else begin
              state_n = STOP;
              txd_n   = 1'b1;
            end
          end else begin
            bit_n = bit_idx + 3'd1;
            txd_n = data_s[bit_idx + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          bit_n   = '0;
          txd_n   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_s && (bit_idx == 3'd0)) begin
            bit_n = 3'd1;
          end else if (can_start) begin
            pop     = 1'b1;
            txd_n   = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  assign tx_busy    = (state != IDLE) || (count != '0);
  assign fifo_level = count;

endmodule
